// File: rtl/dp_jtag_master_if.sv
// rtl/dp_jtag_master_if.sv - command/response and JTAG link signals of dp_jtag_master
interface dp_jtag_master_if #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               rsp_err;
    logic               busy;
    logic               tck;
    logic               tms;
    logic               tdi;
    logic               tdo;

    modport master (
        input  cmd_valid, cmd_op, cmd_len, cmd_data, tdo,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy, tck, tms, tdi
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_len, cmd_data, tdo,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy, tck, tms, tdi
    );
endinterface

// File: rtl/dp_jtag_master.sv
// rtl/dp_jtag_master.sv - JTAG scan master turning IR/DR scan commands into tck/tms/tdi slots
// Define DP_JM_TAP_RESET_CMD_EN to accept op 10 (walk the TAP through Test-Logic-Reset).
module dp_jtag_master #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic             iclk,
    input  logic             reset,
    dp_jtag_master_if.master bus
);
    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_RISE   = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [LEN_W-1:0] TLR_LAST   = LEN_W'(5);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_PRE,
        S_SHIFT,
        S_POST,
        S_RESP
`ifdef DP_JM_TAP_RESET_CMD_EN
        , S_TLR
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   slot_q, slot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ir_q, ir_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;
    logic               err_q, err_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               slot_end;
    logic               op_ok;
    logic               bad_cmd;

    always_ff @(posedge iclk) begin
        if (reset) begin
            state_q    <= S_INIT;
            slot_q     <= '0;
            cnt_q      <= '0;
            ir_q       <= 1'b0;
            len_q      <= '0;
            data_q     <= '0;
            cap_q      <= '0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            cnt_q      <= cnt_d;
            ir_q       <= ir_d;
            len_q      <= len_d;
            data_q     <= data_d;
            cap_q      <= cap_d;
            err_q      <= err_d;
            rsp_data_q <= rsp_data_d;
            tck_q      <= tck_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        cnt_d      = cnt_q;
        ir_d       = ir_q;
        len_d      = len_q;
        data_d     = data_q;
        cap_d      = cap_q;
        err_d      = err_q;
        rsp_data_d = rsp_data_q;
        slot_end   = (cnt_q == CNT_LAST);
`ifdef DP_JM_TAP_RESET_CMD_EN
        op_ok      = (bus.cmd_op != 2'b11);
`else
        op_ok      = !bus.cmd_op[1];
`endif
        bad_cmd    = !op_ok || (bus.cmd_len == '0) || (bus.cmd_len > LEN_W'(MAX_LEN));

        if (state_q != S_IDLE && state_q != S_RESP) begin
            cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_INIT: if (slot_end) begin
                slot_d = slot_q + 1'b1;
                if (slot_q == TLR_LAST) begin
                    slot_d  = '0;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: if (bus.cmd_valid) begin
                ir_d   = (bus.cmd_op == 2'b01);
                len_d  = bus.cmd_len;
                data_d = bus.cmd_data;
                cap_d  = '0;
                slot_d = '0;
                cnt_d  = '0;
                err_d  = bad_cmd;
                if (bad_cmd) begin
                    state_d = S_RESP;
`ifdef DP_JM_TAP_RESET_CMD_EN
                end else if (bus.cmd_op == 2'b10) begin
                    state_d = S_TLR;
`endif
                end else begin
                    state_d = S_PRE;
                end
            end
            S_PRE: if (slot_end) begin
                slot_d = slot_q + 1'b1;
                if (slot_q == (ir_q ? LEN_W'(3) : LEN_W'(2))) begin
                    slot_d  = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // tdo is taken on the iclk edge that raises tck, before the target can change it
                if (cnt_q == CNT_SAMPLE) begin
                    cap_d[slot_q[IDX_W-1:0]] = bus.tdo;
                end
                if (slot_end) begin
                    slot_d = slot_q + 1'b1;
                    if (slot_q == len_q - LEN_W'(1)) begin
                        slot_d  = '0;
                        state_d = S_POST;
                    end
                end
            end
            S_POST: if (slot_end) begin
                slot_d = slot_q + 1'b1;
                if (slot_q == LEN_W'(1)) begin
                    slot_d  = '0;
                    state_d = S_RESP;
                end
            end
`ifdef DP_JM_TAP_RESET_CMD_EN
            S_TLR: if (slot_end) begin
                slot_d = slot_q + 1'b1;
                if (slot_q == TLR_LAST) begin
                    slot_d  = '0;
                    state_d = S_RESP;
                end
            end
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase

        if (state_d == S_RESP && state_q != S_RESP) begin
            rsp_data_d = err_d ? '0 : cap_d;
        end
    end

    // Link pins are decoded from the next state so they leave the flops glitch-free.
    always_comb begin
        tck_d = 1'b0;
        tms_d = 1'b0;
        tdi_d = 1'b0;
        case (state_d)
            S_INIT: begin
                tck_d = (cnt_d >= CNT_RISE);
                tms_d = (slot_d != TLR_LAST);
            end
`ifdef DP_JM_TAP_RESET_CMD_EN
            S_TLR: begin
                tck_d = (cnt_d >= CNT_RISE);
                tms_d = (slot_d != TLR_LAST);
            end
`endif
            S_PRE: begin
                tck_d = (cnt_d >= CNT_RISE);
                tms_d = (slot_d < (ir_d ? LEN_W'(2) : LEN_W'(1)));
            end
            S_SHIFT: begin
                tck_d = (cnt_d >= CNT_RISE);
                tms_d = (slot_d == len_d - LEN_W'(1));
                tdi_d = data_d[slot_d[IDX_W-1:0]];
            end
            S_POST: begin
                tck_d = (cnt_d >= CNT_RISE);
                tms_d = (slot_d == '0);
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_err   = (state_q == S_RESP) && err_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.tck       = tck_q;
    assign bus.tms       = tms_q;
    assign bus.tdi       = tdi_q;
endmodule
